// File: rtl/ram_tester.sv
// ram_tester -- built-in self test sequencer for a small synchronous RAM.
//
// Runs one test when start is sampled high while idle or done. The sequence is:
// write pat(a) = seed + a to every address, then read back and compare every
// address. Each readback takes two cycles (READ, then CMP) because the RAM
// returns Dout one clock after the address is presented. done, pass and
// fail_addr stay valid until the next accepted start or until reset.
//
// Optional feature: define RAM_TESTER_ERRCNT_EN to add the err_count output.
// In that build every word is always checked, and err_count counts the
// mismatches. Without it, the first mismatch ends the test early.
//
// Ports:
//   clk        single clock; all state changes happen on posedge
//   reset      asynchronous, active-high reset
//   start      begins a test when sampled high in IDLE or DONE
//   seed       pattern seed, captured when start is accepted
//   SEL        RAM write select (1 = write Din to addr, 0 = read addr)
//   addr       RAM address
//   Din        RAM write data; 0 whenever SEL = 0
//   Dout       RAM read data, valid one clock after a read address
//   busy       test in progress
//   done       test complete
//   pass       valid while done = 1; 1 = no mismatch found
//   fail_addr  address of the first mismatch; 0 if none
//   err_count  (RAM_TESTER_ERRCNT_EN only) number of mismatches
module ram_tester #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  SEL,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] Din,
    input  logic [DATA_WIDTH-1:0] Dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr
`ifdef RAM_TESTER_ERRCNT_EN
    ,
    output logic [ADDR_WIDTH:0]   err_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   seed_r;
    logic                    mismatch_seen_r;
    logic                    mismatch_s;
    logic                    finish_s;

    // Test pattern for address a: the seed plus a, wrapping at the data width.
    function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                  input logic [ADDR_WIDTH-1:0] a);
        pat = s + DATA_WIDTH'(a);
    endfunction

    // Readback compare and the decision to leave CMP for DONE.
    always_comb begin
        mismatch_s = (Dout != pat(seed_r, addr));
`ifdef RAM_TESTER_ERRCNT_EN
        finish_s   = (addr == LAST_ADDR);
`else
        finish_s   = mismatch_s || (addr == LAST_ADDR);
`endif
    end

    // Sequencer: one FSM that also drives every output as a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            seed_r          <= ZERO_DATA;
            mismatch_seen_r <= 1'b0;
            SEL             <= 1'b0;
            addr            <= ZERO_ADDR;
            Din             <= ZERO_DATA;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_addr       <= ZERO_ADDR;
`ifdef RAM_TESTER_ERRCNT_EN
            err_count       <= {(ADDR_WIDTH+1){1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        // Drive the first write now so it lands on the next edge.
                        state_r         <= WRITE;
                        seed_r          <= seed;
                        mismatch_seen_r <= 1'b0;
                        SEL             <= 1'b1;
                        addr            <= ZERO_ADDR;
                        Din             <= pat(seed, ZERO_ADDR);
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail_addr       <= ZERO_ADDR;
`ifdef RAM_TESTER_ERRCNT_EN
                        err_count       <= {(ADDR_WIDTH+1){1'b0}};
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                WRITE: begin
                    if (addr == LAST_ADDR) begin
                        state_r <= READ;
                        SEL     <= 1'b0;
                        addr    <= ZERO_ADDR;
                        Din     <= ZERO_DATA;
                    end else begin
                        addr    <= addr + 1'b1;
                        Din     <= pat(seed_r, addr + 1'b1);
                    end
                end
                READ: begin
                    // Address is held one cycle so Dout reflects it in CMP.
                    state_r <= CMP;
                end
                CMP: begin
                    if (mismatch_s && !mismatch_seen_r) begin
                        fail_addr       <= addr;
                        mismatch_seen_r <= 1'b1;
                    end else begin
                        fail_addr       <= fail_addr;
                    end
`ifdef RAM_TESTER_ERRCNT_EN
                    if (mismatch_s) begin
                        err_count <= err_count + 1'b1;
                    end else begin
                        err_count <= err_count;
                    end
`endif
                    if (finish_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= ~(mismatch_seen_r | mismatch_s);
                    end else begin
                        state_r <= READ;
                        addr    <= addr + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    SEL     <= 1'b0;
                    addr    <= ZERO_ADDR;
                    Din     <= ZERO_DATA;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_tester.sv
// Self-checking bench for ram_tester: pairs it with a registered-read RAM
// model that can force selected words to a stuck value, runs a table of
// directed vectors, randomized vectors scored against a reference model,
// and hand-written reset / start-while-busy sequences.
module tb_ram_tester;

`ifdef RAM_TESTER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] seed;
    logic       SEL;
    logic [1:0] addr;
    logic [3:0] Din;
    logic [3:0] Dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] fail_addr;
`ifdef RAM_TESTER_ERRCNT_EN
    logic [2:0] err_count;
`endif

    ram_tester #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .SEL(SEL), .addr(addr), .Din(Din), .Dout(Dout),
        .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr)
`ifdef RAM_TESTER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // RAM model with stuck-word injection and a log of what the tester wrote.
    logic [3:0] mem [4];
    logic [3:0] stuck_mask = 4'h0;
    logic [3:0] stuck_val  = 4'h0;
    logic [3:0] wr_data [4];
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (SEL) begin
            mem[addr]     <= stuck_mask[addr] ? stuck_val : Din;
            wr_data[addr] <= Din;
            wr_cnt        <= wr_cnt + 1;
        end else begin
            Dout <= mem[addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome straight from the test rules: which stored words differ
    // from the pattern, the first such address, and when done must appear.
    task automatic model(input logic [3:0] s, input logic [3:0] m, input logic [3:0] v,
                         output logic e_pass, output logic [1:0] e_fail,
                         output int e_lat, output int e_err);
        int first;
        logic [3:0] p;
        first = -1;
        e_err = 0;
        for (int a = 0; a < 4; a++) begin
            p = 4'((int'(s) + a) % 16);
            if ((m[a] ? v : p) != p) begin
                e_err++;
                if (first < 0) first = a;
            end
        end
        e_pass = (e_err == 0);
        e_fail = (first < 0) ? 2'd0 : 2'(first);
        if (ERRCNT || first < 0) e_lat = 12;
        else                     e_lat = 4 + 2 * (first + 1);
    endtask

    // One full run: start is held high through clock 'hold' after acceptance.
    task automatic run_test(input string name, input logic [3:0] s, input logic [3:0] m,
                            input logic [3:0] v, input int hold,
                            input logic e_pass, input logic [1:0] e_fail,
                            input int e_lat, input int e_err);
        int  cyc;
        bit  seen_done;
        logic [3:0] p;
        stuck_mask = m;
        stuck_val  = v;
        wr_cnt     = 0;
        seed       = s;
        start      = 1'b1;
        @(posedge clk); #1;
        if (hold == 0) start = 1'b0;
        check({name, " accept_flags"}, 32'({busy, done, pass}), 32'(3'b100));
        check({name, " accept_wr0"}, 32'({SEL, addr, Din}), 32'({1'b1, 2'd0, s}));
        cyc       = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc >= hold) start = 1'b0;
            if (!SEL) check({name, " din_zero"}, 32'(Din), 32'd0);
            if (done) seen_done = 1'b1;
        end
        check({name, " done_seen"}, 32'(seen_done), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(e_lat));
        check({name, " result"}, 32'({pass, fail_addr}), 32'({e_pass, e_fail}));
        check({name, " idle_outs"}, 32'({busy, SEL, Din}), 32'd0);
        check({name, " wr_cnt"}, 32'(wr_cnt), 32'd4);
        for (int a = 0; a < 4; a++) begin
            p = 4'((int'(s) + a) % 16);
            check({name, " wr_data"}, 32'(wr_data[a]), 32'(p));
        end
`ifdef RAM_TESTER_ERRCNT_EN
        check({name, " err_count"}, 32'(err_count), 32'(e_err));
`else
        if (e_err < 0) check({name, " err_count"}, 32'(e_err), 32'd0);
`endif
    endtask

    typedef struct {
        string      name;
        logic [3:0] seed;
        logic [3:0] mask;
        logic [3:0] val;
        logic       e_pass;
        logic [1:0] e_fail;
        int         e_lat;
        int         e_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic       mp;
        logic [1:0] mf;
        int         ml;
        int         me;
        logic [3:0] rs;
        logic [3:0] rm;
        logic [3:0] rv;

        vecs[0] = '{"clean_E",   4'hE, 4'b0000, 4'h0, 1'b1, 2'd0, 12, 0};
        vecs[1] = '{"b2b_5",     4'h5, 4'b0000, 4'h0, 1'b1, 2'd0, 12, 0};
        vecs[2] = '{"stuck2",    4'h3, 4'b0100, 4'h0, 1'b0, 2'd2, ERRCNT ? 12 : 10, 1};
        vecs[3] = '{"benign0",   4'h0, 4'b0001, 4'h0, 1'b1, 2'd0, 12, 0};
        vecs[4] = '{"stuck0",    4'h7, 4'b0001, 4'hF, 1'b0, 2'd0, ERRCNT ? 12 : 6, 1};
        vecs[5] = '{"stuck1_3",  4'h1, 4'b1010, 4'h0, 1'b0, 2'd1, ERRCNT ? 12 : 8, 2};

        reset = 1'b1;
        start = 1'b0;
        seed  = 4'h0;
        for (int a = 0; a < 4; a++) mem[a] = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({SEL, addr, Din, busy, done, pass, fail_addr}), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", 32'({busy, done, SEL}), 32'd0);

        // Directed table; entry 1 starts straight out of entry 0's DONE.
        for (int i = 0; i < 6; i++) begin
            run_test(vecs[i].name, vecs[i].seed, vecs[i].mask, vecs[i].val, 0,
                     vecs[i].e_pass, vecs[i].e_fail, vecs[i].e_lat, vecs[i].e_err);
        end

        // start held high while busy must not restart the test.
        run_test("start_busy", 4'hA, 4'b0000, 4'h0, 11, 1'b1, 2'd0, 12, 0);

        // Randomized runs scored by the reference model.
        for (int i = 0; i < 20; i++) begin
            rs = 4'($urandom_range(0, 15));
            rm = 4'($urandom_range(0, 15));
            rv = 4'($urandom_range(0, 15));
            model(rs, rm, rv, mp, mf, ml, me);
            run_test("random", rs, rm, rv, 0, mp, mf, ml, me);
        end

        // Reset between clocks 6 and 7 abandons the run; block then stays idle.
        stuck_mask = 4'b0000;
        seed  = 4'h9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midtest_reset_outs", 32'({SEL, addr, Din, busy, done, pass, fail_addr}), 32'd0);
`ifdef RAM_TESTER_ERRCNT_EN
        check("midtest_reset_errc", 32'(err_count), 32'd0);
`endif
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("stay_idle", 32'({busy, done, pass, SEL}), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_tester.md
RAM_TESTER -- requirements
Module: ram_tester

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, RAM address width; the block tests 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 4, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level sampled on posedge; begins a test when the block is idle or done.
REQ-006 seed  input  DATA_WIDTH  pattern seed, captured on an accepted start.
REQ-007 SEL  output  1  RAM write select; 1 = write Din to addr, 0 = read addr.
REQ-008 addr  output  ADDR_WIDTH  RAM address.
REQ-009 Din  output  DATA_WIDTH  RAM write data.
REQ-010 Dout  input  DATA_WIDTH  RAM read data, valid one clock after addr is presented with SEL=0.
REQ-011 busy  output  1  test in progress.
REQ-012 done  output  1  test complete; held until the next accepted start or reset.
REQ-013 pass  output  1  valid while done=1; 1 = no mismatch found.
REQ-014 fail_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.

Function
REQ-015 States: IDLE, WRITE, READ, CMP, DONE; all outputs are registered.
REQ-016 Pattern: pat(a) = (seed_q + a) mod 2**DATA_WIDTH, where seed_q is the captured seed.
REQ-017 IDLE/DONE with start=1: capture seed, clear pass/done/fail_addr, set addr=0, go to WRITE, and set busy=1.
REQ-018 start is ignored in WRITE, READ and CMP.
REQ-019 WRITE: SEL=1, Din=pat(addr); each cycle addr increments; at the last address go to READ with addr=0 and SEL=0.
REQ-020 READ: SEL=0 and addr held for one cycle, then go to CMP.
REQ-021 CMP: compare Dout with pat(addr).
REQ-022 CMP on the last address: go to DONE.
REQ-023 CMP on any other address: increment addr and return to READ.
REQ-024 The first mismatch latches fail_addr=addr; later mismatches never overwrite fail_addr.
REQ-025 DONE: busy=0, done=1, SEL=0; pass=1 if and only if no mismatch occurred.
REQ-026 Latency for N=2**ADDR_WIDTH words: done rises exactly 3N clocks after the accepting edge (12 clocks for the default).
REQ-027 Address counter wrap: the address is compared for terminal value; it never increments past 2**ADDR_WIDTH-1.
REQ-028 Din is 0 whenever SEL=0.

Reset
REQ-029 reset=1 forces state IDLE immediately, independent of clk.
REQ-030 reset=1 forces SEL=0, addr=0, Din=0, busy=0, done=0, pass=0, fail_addr=0.
REQ-031 Reset asserted mid-test abandons the test with no partial result reported.
REQ-032 After reset is released, a new start is required to begin a test.

Configuration
REQ-033 Macro RAM_TESTER_ERRCNT_EN defined: add output err_count (ADDR_WIDTH+1 bits, reset 0, cleared on start).
REQ-034 With RAM_TESTER_ERRCNT_EN defined: err_count increments on each CMP mismatch, and the test always checks all N words.
REQ-035 Macro undefined: no err_count port; the first CMP mismatch goes directly to DONE with pass=0.

Verification (bench pairs the tester with a registered-read RAM model: write on SEL=1, Dout<=mem[addr] on SEL=0)
REQ-036 Clean test: seed=4'hE, start pulse -> writes E,F,0,1 to addr 0..3; done at clock 12 with pass=1 and fail_addr=0.
REQ-037 Stuck fault: model forces mem[2]=4'h0, seed=4'h3 -> pass=0 and fail_addr=2. Macro undefined: done at clock 10. Macro defined: done at clock 12 with err_count=1.
REQ-038 Reset mid-test: assert reset between clocks 6 and 7 -> all outputs are 0 before the next edge; start held low -> the block stays in IDLE.
REQ-039 Start while busy: start=1 for clocks 1..11 -> the test is not restarted; done still occurs at clock 12.
REQ-040 Back-to-back runs: start in DONE with seed=4'h5 -> done/pass clear on the next edge; the second run completes with pass=1 at clock 12 relative to its own start.
